// File: rtl/rvx_wb_bridge_if.sv
// Wishbone classic bus bundle between rvx_wb_bridge and the Controller core_* port.
interface rvx_wb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [ADDR_WIDTH-1:0]   wb_addr_o;
    logic [DATA_WIDTH-1:0]   wb_data_o;
    logic [DATA_WIDTH-1:0]   wb_data_i;
    logic                    wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/rvx_wb_bridge.sv
// Core level-request/pulse-response to registered Wishbone classic master,
// one outstanding transaction, with an ack timeout that sets a sticky error.
module rvx_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   core_rw_address_i,
    input  logic                    core_read_request_i,
    input  logic                    core_write_request_i,
    input  logic [DATA_WIDTH-1:0]   core_write_data_i,
    input  logic [DATA_WIDTH/8-1:0] core_write_strobe_i,
    output logic [DATA_WIDTH-1:0]   core_read_data_o,
    output logic                    core_read_response_o,
    output logic                    core_write_response_o,
    rvx_wb_bridge_if.master         wb,
    output logic                    bus_error_o
);
    localparam int          SW     = DATA_WIDTH / 8;
    localparam logic [31:0] TMO    = TIMEOUT_CYCLES;
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                  state, state_n;
    logic                    cyc, cyc_n;
    logic                    we, we_n;
    logic [SW-1:0]           sel, sel_n;
    logic [ADDR_WIDTH-1:0]   addr, addr_n;
    logic [DATA_WIDTH-1:0]   wdat, wdat_n;
    logic [DATA_WIDTH-1:0]   rdat, rdat_n;
    logic                    rresp, rresp_n;
    logic                    wresp, wresp_n;
    logic                    err, err_n;
    logic [31:0]             cnt, cnt_n;
    logic                    tmo;

    // Abort on the cycle the wait count would reach the limit.
    assign tmo = TMO_EN && ((cnt + 32'd1) == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cyc   <= 1'b0;
            we    <= 1'b0;
            sel   <= '0;
            addr  <= '0;
            wdat  <= '0;
            rdat  <= '0;
            rresp <= 1'b0;
            wresp <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            we    <= we_n;
            sel   <= sel_n;
            addr  <= addr_n;
            wdat  <= wdat_n;
            rdat  <= rdat_n;
            rresp <= rresp_n;
            wresp <= wresp_n;
            err   <= err_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        we_n    = we;
        sel_n   = sel;
        addr_n  = addr;
        wdat_n  = wdat;
        rdat_n  = rdat;
        rresp_n = 1'b0;
        wresp_n = 1'b0;
        err_n   = err;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (core_write_request_i) begin
                    state_n = WRITE;
                    cyc_n   = 1'b1;
                    we_n    = 1'b1;
                    sel_n   = core_write_strobe_i;
                    addr_n  = core_rw_address_i;
                    wdat_n  = core_write_data_i;
                end else if (core_read_request_i) begin
                    state_n = READ;
                    cyc_n   = 1'b1;
                    we_n    = 1'b0;
                    sel_n   = '1;
                    addr_n  = core_rw_address_i;
                    wdat_n  = core_write_data_i;
                end
            end
            READ, WRITE: begin
                // Ack has priority over a timeout landing on the same edge.
                if (wb.wb_ack_i) begin
                    state_n = RESP;
                    cyc_n   = 1'b0;
                    cnt_n   = '0;
                    rresp_n = (state == READ);
                    wresp_n = (state == WRITE);
                    if (state == READ) rdat_n = wb.wb_data_i;
                end else if (tmo) begin
                    state_n = RESP;
                    cyc_n   = 1'b0;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    rresp_n = (state == READ);
                    wresp_n = (state == WRITE);
                    if (state == READ) rdat_n = '0;
                end else if (TMO_EN) begin
                    cnt_n = cnt + 32'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign wb.wb_cyc_o  = cyc;
    assign wb.wb_stb_o  = cyc;
    assign wb.wb_we_o   = we;
    assign wb.wb_sel_o  = sel;
    assign wb.wb_addr_o = addr;
    assign wb.wb_data_o = wdat;

    assign core_read_data_o      = rdat;
    assign core_read_response_o  = rresp;
    assign core_write_response_o = wresp;
    assign bus_error_o           = err;
endmodule

// File: tb/tb_rvx_wb_bridge.sv
// Randomized self-checking bench for rvx_wb_bridge against a transaction-level model
// of latency, wait states, timeout and sticky error.
module tb_rvx_wb_bridge;
    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        rreq;
    logic        wreq;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rresp;
    logic        wresp;
    logic        berr;

    rvx_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    rvx_wb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .core_rw_address_i(addr),
        .core_read_request_i(rreq),
        .core_write_request_i(wreq),
        .core_write_data_i(wdata),
        .core_write_strobe_i(wstrb),
        .core_read_data_o(rdata),
        .core_read_response_o(rresp),
        .core_write_response_o(wresp),
        .wb(bus),
        .bus_error_o(berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observations of the latest transaction
    int          n_rresp, n_wresp, lat_r, lat_w, cyc_len, extra_cyc;
    bit          unstable;
    bit          q_we[$];
    bit          q_ord[$];
    logic [3:0]  o_sel;
    logic [31:0] o_addr, o_data, o_rdata;
    logic        o_we;
    logic [31:0] last_rd;

    // Spec-level model: ack in stb cycle waits+1 unless the timeout comes first.
    function automatic void model(input int waits, output int len,
                                  output int lat, output bit err);
        if (waits + 1 <= TO) begin
            len = waits + 1;
            err = 1'b0;
        end else begin
            len = TO;
            err = 1'b1;
        end
        lat = len + 1;
    endfunction

    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input int waits, input logic [31:0] sd, input int tail);
        bit got_r, got_w, prev, done;
        n_rresp = 0; n_wresp = 0; lat_r = 0; lat_w = 0;
        cyc_len = 0; extra_cyc = 0; unstable = 0;
        q_we.delete(); q_ord.delete();
        addr = a; wdata = wd; wstrb = st; wreq = wr; rreq = rd;
        bus.wb_data_i = sd; bus.wb_ack_i = 1'b0;
        prev = 0; done = 0; got_r = 0; got_w = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.wb_cyc_o) begin
                if (!prev) begin
                    cyc_len = 0;
                    q_we.push_back(bus.wb_we_o);
                    o_sel = bus.wb_sel_o; o_addr = bus.wb_addr_o;
                    o_data = bus.wb_data_o; o_we = bus.wb_we_o;
                end else if ({bus.wb_we_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o}
                             != {o_we, o_sel, o_addr, o_data}) begin
                    unstable = 1;
                end
                if (bus.wb_stb_o !== 1'b1) unstable = 1;
                cyc_len++;
            end
            prev = bus.wb_cyc_o;
            bus.wb_ack_i = bus.wb_cyc_o && (cyc_len == waits + 1);
            if (rresp) begin
                n_rresp++; got_r = 1; lat_r = c; o_rdata = rdata;
                rreq = 0; q_ord.push_back(1'b1);
            end
            if (wresp) begin
                n_wresp++; got_w = 1; lat_w = c;
                wreq = 0; q_ord.push_back(1'b0);
            end
            done = (got_r || !rd) && (got_w || !wr);
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL txn_done: got r=%0b w=%0b expected r=%0b w=%0b",
                     got_r, got_w, rd, wr);
        end
        rreq = 0; wreq = 0; bus.wb_ack_i = 1'b0;
        for (int c = 0; c < tail; c++) begin
            @(posedge clk); @(negedge clk);
            if (rresp) n_rresp++;
            if (wresp) n_wresp++;
            if (bus.wb_cyc_o) extra_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr = '0; rreq = 0; wreq = 0; wdata = '0; wstrb = '0;
        bus.wb_data_i = '0; bus.wb_ack_i = 1'b0;
        #3;
        tests++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctl: got %b expected 000",
                     {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o});
        end
        tests++;
        if ({bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o} !== '0) begin
            fails++;
            $display("FAIL reset_bus: got %h/%h/%h expected 0",
                     bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o);
        end
        tests++;
        if ({rdata, rresp, wresp, berr} !== '0) begin
            fails++;
            $display("FAIL reset_core: got %h %b%b%b expected 0",
                     rdata, rresp, wresp, berr);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        last_rd = '0;
    endtask

    task automatic test_read();
        do_txn(0, 1, 32'h100, $urandom, 4'h3, 2, 32'h1234_5678, 3);
        tests++;
        if (cyc_len != 3 || o_sel !== 4'hF || o_we !== 1'b0 || o_addr !== 32'h100) begin
            fails++;
            $display("FAIL read_bus: got len=%0d sel=%h we=%b a=%h expected 3 f 0 100",
                     cyc_len, o_sel, o_we, o_addr);
        end
        tests++;
        if (n_rresp != 1 || n_wresp != 0 || o_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL read_resp: got r=%0d w=%0d d=%h expected 1 0 12345678",
                     n_rresp, n_wresp, o_rdata);
        end
        tests++;
        if (lat_r != 4 || unstable || extra_cyc != 0) begin
            fails++;
            $display("FAIL read_lat: got lat=%0d unst=%0b x=%0d expected 4 0 0",
                     lat_r, unstable, extra_cyc);
        end
        last_rd = 32'h1234_5678;
    endtask

    task automatic test_write();
        do_txn(1, 0, 32'h204, 32'hAABB_CCDD, 4'b0010, 1, $urandom, 3);
        tests++;
        if (o_we !== 1'b1 || o_sel !== 4'b0010 || o_data !== 32'hAABB_CCDD
            || o_addr !== 32'h204) begin
            fails++;
            $display("FAIL write_bus: got we=%b sel=%b d=%h a=%h expected 1 0010 aabbccdd 204",
                     o_we, o_sel, o_data, o_addr);
        end
        tests++;
        if (n_wresp != 1 || n_rresp != 0 || lat_w != 3 || cyc_len != 2) begin
            fails++;
            $display("FAIL write_resp: got w=%0d r=%0d lat=%0d len=%0d expected 1 0 3 2",
                     n_wresp, n_rresp, lat_w, cyc_len);
        end
        tests++;
        if (rdata !== last_rd) begin
            fails++;
            $display("FAIL write_rdata_hold: got %h expected %h", rdata, last_rd);
        end
    endtask

    task automatic test_both();
        logic [31:0] d;
        d = $urandom;
        do_txn(1, 1, 32'h300, 32'h5555_AAAA, 4'hC, 0, d, 3);
        tests++;
        if (q_we.size() != 2 || q_ord.size() != 2) begin
            fails++;
            $display("FAIL both_count: got cyc=%0d resp=%0d expected 2 2",
                     q_we.size(), q_ord.size());
        end else begin
            tests++;
            if (q_we[0] !== 1'b1 || q_we[1] !== 1'b0 || q_ord[0] !== 1'b0
                || q_ord[1] !== 1'b1) begin
                fails++;
                $display("FAIL both_order: got we=%b%b ord=%b%b expected 10 01",
                         q_we[0], q_we[1], q_ord[0], q_ord[1]);
            end
        end
        tests++;
        if (n_rresp != 1 || n_wresp != 1 || o_rdata !== d || lat_w != 2
            || lat_r != 5 || o_sel !== 4'hF) begin
            fails++;
            $display("FAIL both_resp: got r=%0d w=%0d d=%h lw=%0d lr=%0d sel=%h expected 1 1 %h 2 5 f",
                     n_rresp, n_wresp, o_rdata, lat_w, lat_r, o_sel, d);
        end
        last_rd = d;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            bit          wr, eerr;
            int          w, elen, elat;
            logic [31:0] a, wd, sd;
            logic [3:0]  st;
            wr = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 6);
            a  = $urandom; wd = $urandom; sd = $urandom;
            st = (i == 0) ? 4'h0 : 4'($urandom);
            model(w, elen, elat, eerr);
            do_txn(wr, !wr, a, wd, st, w, sd, 2);
            tests++;
            if (cyc_len != elen || o_addr !== a || o_we !== wr || unstable) begin
                fails++;
                $display("FAIL rnd_bus[%0d]: got len=%0d a=%h we=%b unst=%0b expected %0d %h %b 0",
                         i, cyc_len, o_addr, o_we, unstable, elen, a, wr);
            end
            if (wr) begin
                tests++;
                if (o_sel !== st || o_data !== wd || n_wresp != 1 || n_rresp != 0
                    || lat_w != elat || rdata !== last_rd) begin
                    fails++;
                    $display("FAIL rnd_wr[%0d]: got sel=%h d=%h n=%0d/%0d lat=%0d rd=%h expected %h %h 1/0 %0d %h",
                             i, o_sel, o_data, n_wresp, n_rresp, lat_w, rdata,
                             st, wd, elat, last_rd);
                end
            end else begin
                tests++;
                if (o_sel !== 4'hF || o_rdata !== sd || n_rresp != 1 || n_wresp != 0
                    || lat_r != elat) begin
                    fails++;
                    $display("FAIL rnd_rd[%0d]: got sel=%h d=%h n=%0d/%0d lat=%0d expected f %h 1/0 %0d",
                             i, o_sel, o_rdata, n_rresp, n_wresp, lat_r, sd, elat);
                end
                last_rd = sd;
            end
            tests++;
            if (berr !== eerr) begin
                fails++;
                $display("FAIL rnd_err[%0d]: got %b expected %b", i, berr, eerr);
            end
        end
    endtask

    task automatic test_ack_at_timeout();
        logic [31:0] d;
        d = $urandom;
        do_txn(0, 1, 32'h400, '0, 4'h0, TO - 1, d, 2);
        tests++;
        if (cyc_len != TO || lat_r != TO + 1 || o_rdata !== d || berr !== 1'b0) begin
            fails++;
            $display("FAIL ack_tie: got len=%0d lat=%0d d=%h err=%b expected %0d %0d %h 0",
                     cyc_len, lat_r, o_rdata, berr, TO, TO + 1, d);
        end
        last_rd = d;
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        do_txn(0, 1, 32'h500, '0, 4'h0, 1000, 32'hDEAD_BEEF, 3);
        tests++;
        if (cyc_len != TO || lat_r != TO + 1 || n_rresp != 1 || extra_cyc != 0) begin
            fails++;
            $display("FAIL tmo_timing: got len=%0d lat=%0d n=%0d x=%0d expected %0d %0d 1 0",
                     cyc_len, lat_r, n_rresp, extra_cyc, TO, TO + 1);
        end
        tests++;
        if (o_rdata !== 32'h0 || berr !== 1'b1) begin
            fails++;
            $display("FAIL tmo_data: got d=%h err=%b expected 0 1", o_rdata, berr);
        end
        last_rd = '0;
        d = $urandom;
        do_txn(0, 1, 32'h504, '0, 4'h0, 0, d, 2);
        do_txn(1, 0, 32'h508, $urandom, 4'hF, 3, '0, 2);
        tests++;
        if (berr !== 1'b1 || n_wresp != 1 || rdata !== d) begin
            fails++;
            $display("FAIL tmo_sticky: got err=%b w=%0d rd=%h expected 1 1 %h",
                     berr, n_wresp, rdata, d);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        addr = 32'h600; wdata = $urandom; wstrb = 4'hF; wreq = 1; rreq = 0;
        bus.wb_ack_i = 1'b0;
        @(posedge clk); @(negedge clk);
        tests++;
        if (bus.wb_cyc_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: got cyc=%b expected 1", bus.wb_cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, berr} !== 3'b000) begin
            fails++;
            $display("FAIL rst_mid_async: got cyc/stb/err=%b expected 000",
                     {bus.wb_cyc_o, bus.wb_stb_o, berr});
        end
        wreq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_ack_i = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (rresp || wresp || bus.wb_cyc_o) bad++;
        end
        bus.wb_ack_i = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rst_mid_stray_ack: got %0d active cycles expected 0", bad);
        end
        last_rd = '0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, d;
            int          elat;
            a = $urandom; d = $urandom;
            // Follow-ups are driven during the response cycle, one edge before IDLE.
            elat = (i == 0) ? 2 : 3;
            do_txn(0, 1, a, '0, 4'h0, 0, d, (i == 5) ? 3 : 0);
            tests++;
            if (o_rdata !== d || lat_r != elat || cyc_len != 1 || o_addr !== a) begin
                fails++;
                $display("FAIL b2b[%0d]: got d=%h lat=%0d len=%0d a=%h expected %h %0d 1 %h",
                         i, o_rdata, lat_r, cyc_len, o_addr, d, elat, a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both();
        test_random();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
